// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluation and fetch sequencer: scans OAM for hits on the next line,
// then streams one graphics row per slot. Optional macro SPRITE_VFLIP_EN enables vertical flip.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES = 64,
  parameter int MAX_SLOTS   = 8,
  parameter int SPRITE_H    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [9:0]             line,
  output logic [7:0]             oam_addr,
  input  logic [31:0]            oam_rdata,
  output logic [10:0]            spr_addr,
  input  logic [31:0]            spr_rdata,
  output logic                   load_valid,
  output logic [2:0]             load_idx,
  output logic [31:0]            load_data,
  output logic [MAX_SLOTS*10-1:0] slot_x,
  output logic [MAX_SLOTS*3-1:0]  slot_pal,
  output logic [MAX_SLOTS-1:0]   slot_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int RW  = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int CW  = $clog2(NUM_SPRITES + 1);
  localparam int HW  = $clog2(MAX_SLOTS + 1);
  localparam int SIW = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, FETCH} state_e;

  state_e                         state_q, state_d;
  logic [9:0]                     line_q, line_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [7:0]                     oam_addr_q, oam_addr_d;
  logic [HW-1:0]                  hits_q, hits_d;
  logic [HW-1:0]                  fcnt_q, fcnt_d;
  logic [6:0]                     tile_q [MAX_SLOTS];
  logic [6:0]                     tile_d [MAX_SLOTS];
  logic [RW-1:0]                  row_q  [MAX_SLOTS];
  logic [RW-1:0]                  row_d  [MAX_SLOTS];
  logic [9:0]                     x_q    [MAX_SLOTS];
  logic [9:0]                     x_d    [MAX_SLOTS];
  logic [2:0]                     pal_q  [MAX_SLOTS];
  logic [2:0]                     pal_d  [MAX_SLOTS];
  logic                           load_valid_q, load_valid_d;
  logic [2:0]                     load_idx_q, load_idx_d;
  logic                           ld_hit_q, ld_hit_d;
  logic [MAX_SLOTS-1:0][9:0]      slot_x_q, slot_x_d;
  logic [MAX_SLOTS-1:0][2:0]      slot_pal_q, slot_pal_d;
  logic [MAX_SLOTS-1:0]           slot_valid_q, slot_valid_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           overflow_q, overflow_d;

  // Evaluation of the OAM entry returned this cycle (issued the cycle before).
  logic [9:0]    ev_row;
  logic          ev_hit;
  logic [RW-1:0] ev_frow;

  assign ev_row = line_q - oam_rdata[9:0];
  assign ev_hit = oam_rdata[31] && (ev_row < 10'(SPRITE_H));

`ifdef SPRITE_VFLIP_EN
  assign ev_frow = oam_rdata[27] ? (RW'(SPRITE_H - 1) - ev_row[RW-1:0]) : ev_row[RW-1:0];
`else
  logic unused_vflip;
  assign unused_vflip = oam_rdata[27];
  assign ev_frow      = ev_row[RW-1:0];
`endif

  logic [SIW-1:0] fidx;
  logic [SIW-1:0] aidx;
  logic           f_has;

  assign fidx  = fcnt_q[SIW-1:0];
  assign aidx  = hits_q[SIW-1:0];
  assign f_has = (state_q == FETCH) && (fcnt_q < hits_q);

  // Graphics address is driven during the issue cycle; data returns with the load cycle.
  assign spr_addr   = f_has ? ((11'(tile_q[fidx]) * 11'(SPRITE_H)) + 11'(row_q[fidx])) : 11'd0;
  assign oam_addr   = oam_addr_q;
  assign load_valid = load_valid_q;
  assign load_idx   = load_idx_q;
  assign load_data  = (load_valid_q && ld_hit_q) ? spr_rdata : 32'd0;
  assign slot_x     = slot_x_q;
  assign slot_pal   = slot_pal_q;
  assign slot_valid = slot_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    cnt_d        = cnt_q;
    oam_addr_d   = oam_addr_q;
    hits_d       = hits_q;
    fcnt_d       = fcnt_q;
    tile_d       = tile_q;
    row_d        = row_q;
    x_d          = x_q;
    pal_d        = pal_q;
    load_valid_d = 1'b0;
    load_idx_d   = load_idx_q;
    ld_hit_d     = 1'b0;
    slot_x_d     = slot_x_q;
    slot_pal_d   = slot_pal_q;
    slot_valid_d = slot_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    overflow_d   = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SCAN;
          line_d     = line;
          cnt_d      = '0;
          oam_addr_d = 8'd0;
          hits_d     = '0;
          overflow_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + CW'(1);
        if (oam_addr_q != 8'(NUM_SPRITES - 1)) oam_addr_d = oam_addr_q + 8'd1;
        if (cnt_q != '0) begin
          if (ev_hit && (hits_q == HW'(MAX_SLOTS))) begin
            overflow_d = 1'b1;
            state_d    = FETCH;
            fcnt_d     = '0;
          end else begin
            if (ev_hit) begin
              tile_d[aidx] = oam_rdata[26:20];
              row_d[aidx]  = ev_frow;
              x_d[aidx]    = oam_rdata[19:10];
              pal_d[aidx]  = oam_rdata[30:28];
              hits_d       = hits_q + HW'(1);
            end
            if (cnt_q == CW'(NUM_SPRITES)) begin
              state_d = FETCH;
              fcnt_d  = '0;
            end
          end
        end
      end
      FETCH: begin
        fcnt_d = fcnt_q + HW'(1);
        if (fcnt_q < HW'(MAX_SLOTS)) begin
          // Empty slots still get a load so the shift register is cleared to transparent.
          load_valid_d       = 1'b1;
          load_idx_d         = 3'(fcnt_q);
          ld_hit_d           = f_has;
          slot_valid_d[fidx] = f_has;
          slot_x_d[fidx]     = f_has ? x_q[fidx] : 10'd0;
          slot_pal_d[fidx]   = f_has ? pal_q[fidx] : 3'd0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      line_q       <= '0;
      cnt_q        <= '0;
      oam_addr_q   <= '0;
      hits_q       <= '0;
      fcnt_q       <= '0;
      for (int i = 0; i < MAX_SLOTS; i++) begin
        tile_q[i] <= '0;
        row_q[i]  <= '0;
        x_q[i]    <= '0;
        pal_q[i]  <= '0;
      end
      load_valid_q <= 1'b0;
      load_idx_q   <= '0;
      ld_hit_q     <= 1'b0;
      slot_x_q     <= '0;
      slot_pal_q   <= '0;
      slot_valid_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      cnt_q        <= cnt_d;
      oam_addr_q   <= oam_addr_d;
      hits_q       <= hits_d;
      fcnt_q       <= fcnt_d;
      tile_q       <= tile_d;
      row_q        <= row_d;
      x_q          <= x_d;
      pal_q        <= pal_d;
      load_valid_q <= load_valid_d;
      load_idx_q   <= load_idx_d;
      ld_hit_q     <= ld_hit_d;
      slot_x_q     <= slot_x_d;
      slot_pal_q   <= slot_pal_d;
      slot_valid_q <= slot_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench for sprite_line_scheduler: a line-level reference model queues expected
// slot loads and done events; a negedge monitor compares whatever the DUT presents.
module tb_sprite_line_scheduler;
  localparam int NS = 64;
  localparam int MS = 8;
  localparam int H  = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [9:0]       line;
  logic [7:0]       oam_addr;
  logic [31:0]      oam_rdata;
  logic [10:0]      spr_addr;
  logic [31:0]      spr_rdata;
  logic             load_valid;
  logic [2:0]       load_idx;
  logic [31:0]      load_data;
  logic [MS*10-1:0] slot_x;
  logic [MS*3-1:0]  slot_pal;
  logic [MS-1:0]    slot_valid;
  logic             busy, done, overflow;

  logic [31:0] oam     [NS];
  logic [31:0] spr_mem [2048];

  typedef struct {int idx; logic [31:0] data; logic [9:0] x; logic [2:0] pal; logic valid;} load_t;
  typedef struct {int cyc; logic ovf; logic [MS-1:0] mask;} done_t;

  load_t load_q[$];
  done_t done_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc   = 0;
  logic  last_ovf;

  sprite_line_scheduler #(.NUM_SPRITES(NS), .MAX_SLOTS(MS), .SPRITE_H(H)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .line(line),
    .oam_addr(oam_addr), .oam_rdata(oam_rdata), .spr_addr(spr_addr), .spr_rdata(spr_rdata),
    .load_valid(load_valid), .load_idx(load_idx), .load_data(load_data),
    .slot_x(slot_x), .slot_pal(slot_pal), .slot_valid(slot_valid),
    .busy(busy), .done(done), .overflow(overflow));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    oam_rdata <= oam[oam_addr[5:0]];
    spr_rdata <= spr_mem[spr_addr];
    cyc       <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(bit en, int pal, bit vf, int tile, int x, int y);
    return {en, 3'(pal), vf, 7'(tile), 10'(x), 10'(y)};
  endfunction

  // Monitor: every load and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    load_t l;
    done_t d;
    if (reset_n) begin
      if (load_valid) begin
        if (load_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_load: slot %0d loaded, no load expected", load_idx);
        end else begin
          l = load_q.pop_front();
          check("load_idx", 64'(load_idx), 64'(l.idx));
          check("load_data", 64'(load_data), 64'(l.data));
          check("slot_valid_bit", 64'(slot_valid[l.idx]), 64'(l.valid));
          if (l.valid) begin
            check("slot_x", 64'(slot_x[l.idx*10 +: 10]), 64'(l.x));
            check("slot_pal", 64'(slot_pal[l.idx*3 +: 3]), 64'(l.pal));
          end
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: done pulsed, none expected");
        end else begin
          d = done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(d.cyc));
          check("overflow", 64'(overflow), 64'(d.ovf));
          check("slot_valid_mask", 64'(slot_valid), 64'(d.mask));
          check("busy_at_done", 64'(busy), 64'd0);
        end
      end
    end
  end

  // Reference model: apply the line's selection rules to the whole OAM, queue the results.
  task automatic issue(input logic [9:0] ln, input bit poke_busy);
    int         hits[$];
    bit         ovf;
    int         j, frow, scan_len;
    logic [9:0] row;
    logic [31:0] w;
    load_t      l;
    done_t      d;
    ovf = 0; j = 0;
    for (int k = 0; k < NS; k++) begin
      w   = oam[k];
      row = ln - w[9:0];
      if (w[31] && row < 10'(H)) begin
        if (hits.size() == MS) begin ovf = 1; j = k; break; end
        hits.push_back(k);
      end
    end
    scan_len = ovf ? j + 2 : NS + 1;
    d.mask = '0;
    d.ovf  = ovf;
    @(negedge clk);
    for (int s = 0; s < MS; s++) begin
      l.idx = s; l.data = 32'd0; l.x = 10'd0; l.pal = 3'd0; l.valid = 1'b0;
      if (s < hits.size()) begin
        w    = oam[hits[s]];
        row  = ln - w[9:0];
        frow = int'(row);
`ifdef SPRITE_VFLIP_EN
        if (w[27]) frow = H - 1 - frow;
`endif
        l.data  = spr_mem[int'(w[26:20]) * H + frow];
        l.x     = w[19:10];
        l.pal   = w[30:28];
        l.valid = 1'b1;
        d.mask[s] = 1'b1;
      end
      load_q.push_back(l);
    end
    d.cyc = cyc + scan_len + MS + 2;
    done_q.push_back(d);
    last_ovf = ovf;
    start = 1'b1;
    line  = ln;
    @(negedge clk);
    start = 1'b0;
    line  = 10'($urandom);
    check("busy_after_start", 64'(busy), 64'd1);
    if (poke_busy) begin
      repeat (8) @(negedge clk);
      start = 1'b1;
      line  = 10'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((load_q.size() != 0 || done_q.size() != 0) && t < 200) begin
      @(negedge clk); #1; t++;
    end
    if (load_q.size() != 0 || done_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL timeout: %0d loads and %0d done still pending, expected 0", load_q.size(), done_q.size());
      load_q.delete(); done_q.delete();
    end
    repeat (3) @(negedge clk);
    check("overflow_held", 64'(overflow), 64'(last_ovf));
  endtask

  task automatic check_zero();
    check("rst_oam_addr", 64'(oam_addr), 64'd0);
    check("rst_spr_addr", 64'(spr_addr), 64'd0);
    check("rst_load_valid", 64'(load_valid), 64'd0);
    check("rst_load_idx", 64'(load_idx), 64'd0);
    check("rst_load_data", 64'(load_data), 64'd0);
    check("rst_slot_x", 64'(|slot_x), 64'd0);
    check("rst_slot_pal", 64'(|slot_pal), 64'd0);
    check("rst_slot_valid", 64'(slot_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
  endtask

  task automatic clear_oam();
    for (int k = 0; k < NS; k++) oam[k] = 32'd0;
  endtask

  initial begin
    int t;
    reset_n = 1'b0; start = 1'b0; line = 10'd0; last_ovf = 1'b0;
    for (int a = 0; a < 2048; a++) spr_mem[a] = $urandom;
    clear_oam();
    repeat (3) @(negedge clk);
    check_zero();
    reset_n = 1'b1;
    @(negedge clk);

    // Empty OAM: eight transparent loads, full-length scan.
    issue(10'd100, 1'b0);
    wait_idle();

    // Single sprite at OAM 5, row 7 of tile 3.
    clear_oam();
    oam[5] = mk(1, 2, 0, 3, 40, 100);
    issue(10'd107, 1'b0);
    wait_idle();

    // Ten sprites on the same line: first eight win, early overflow.
    clear_oam();
    for (int k = 0; k < 10; k++) oam[k] = mk(1, k % 8, 0, k + 20, 16 * k, 20);
    issue(10'd20, 1'b0);
    wait_idle();

    // Rows that wrap around the 10-bit line space.
    clear_oam();
    oam[0] = mk(1, 1, 0, 9, 100, 1020);
    oam[1] = mk(1, 4, 0, 10, 200, 5);
    issue(10'd4, 1'b0);
    wait_idle();

    // Vertical flip attribute.
    clear_oam();
    oam[2] = mk(1, 5, 1, 1, 77, 0);
    issue(10'd2, 1'b0);
    wait_idle();

    // Randomized OAM contents and lines, with stray starts while busy.
    for (int it = 0; it < 24; it++) begin
      logic [9:0] ln;
      int dens;
      ln   = 10'($urandom);
      dens = $urandom_range(0, 7);
      for (int k = 0; k < NS; k++) begin
        int off;
        off = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 24));
        oam[k] = mk(($urandom_range(0, 15) < dens), $urandom, $urandom, $urandom, $urandom, int'(ln) - off);
      end
      issue(ln, (it % 3) == 0);
      wait_idle();
    end

    // Asynchronous reset in the middle of FETCH aborts the line.
    clear_oam();
    for (int k = 0; k < 4; k++) oam[k * 7] = mk(1, k, 0, k + 40, k * 30, 300);
    issue(10'd305, 1'b0);
    t = 0;
    while (load_q.size() > MS - 3 && t < 200) begin @(negedge clk); #1; t++; end
    check("reached_fetch", 64'(load_q.size() <= MS - 3), 64'd1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    load_q.delete(); done_q.delete();
    #1;
    check_zero();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_after_abort", 64'(busy), 64'd0);

    // Recovery run after the abort.
    issue(10'd303, 1'b0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
